fpu_dp_divider: RTL and testbench
=================================

Name: fpu_dp_divider

Overview:
- Iterative IEEE-754 double-precision divider: result = A / B.
- Complements the combinational double-precision multiplier in the FPU common library.
- Arithmetic scope and flag behaviour match the multiplier: truncation (no rounding), implicit-bit handling for exponent 0, overflow/underflow flags, no NaN/Inf decoding.
- Restoring radix-2 division, one quotient bit per clock, with a start/done handshake.

Parameters:
- WIDTH, 64, operand/result width; only 64 is supported (field positions are fixed to binary64).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  dividend; captured on the accepting edge.
- B  input  WIDTH  divisor; captured on the accepting edge.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse when result and flags become valid.
- result  output  WIDTH  quotient; held until the next accepted start.
- overflow  output  1  exponent too large; held with result.
- underflow  output  1  exponent too small with non-zero dividend; held with result.
- div_by_zero  output  1  B exponent and mantissa both zero; held with result.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, result, overflow, underflow and div_by_zero all 0; internal registers cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE -> CALC -> NORM -> DONE -> IDLE.
  - IDLE: start=1 captures A and B, goes to CALC, and busy rises.
  - CALC: exactly 55 cycles, one quotient bit per cycle, MSB first; iteration counter 6 bits.
  - NORM: 1 cycle; selects the mantissa, forms the exponent, evaluates flags, loads the output registers.
  - DONE: done=1 for one cycle, busy=0; returns to IDLE.
- Latency: done is high in the cycle after the 57th rising edge following the accepting edge. Latency is fixed for all operands, including zero cases.
- start outside IDLE (including the DONE cycle) is ignored; captured operands are not disturbed.
- Operand decode: sign = A[63]^B[63]. Ma = {|A[62:52], A[51:0]}; Mb = {|B[62:52], B[51:0]} (53 bits each).
- Quotient: Q = floor(Ma·2^54 / Mb), 55 bits. Remainder register 55 bits. Each cycle: shift left, trial-subtract Mb, restore if negative, shift in the quotient bit.
- Normalization:
  - Q[54]=1: mantissa = Q[53:2], E = Ea − Eb + 1023.
  - Else: mantissa = Q[52:1], E = Ea − Eb + 1022.
  - E is computed as 13-bit signed.
- Priority in NORM, first match wins:
  1. div_by_zero: result = {sign, 11'h7FF, 52'd0}; overflow = underflow = 0.
  2. A zero (exponent and mantissa 0): result = {sign, 63'd0}; no flags set.
  3. E ≥ 2047: overflow = 1; result = {sign, 11'h7FF, 52'd0}.
  4. E ≤ 0: underflow = 1; result = {sign, 63'd0}.
  5. Otherwise: result = {sign, E[10:0], mantissa}.
- Exponent 2047 inputs are treated as ordinary values; no NaN/Inf special-casing.
- Flags and result update only in NORM. They are stable from done until the next NORM.

Test Plan:
- 6.0/2.0: A=0x4018000000000000, B=0x4000000000000000 -> result=0x4008000000000000, flags 0, done exactly 57 edges after accept.
- 1.0/3.0: A=0x3FF0000000000000, B=0x4008000000000000 -> result=0x3FD5555555555555 (truncated); −2.0/0.5: 0xC000000000000000 / 0x3FE0000000000000 -> 0xC010000000000000.
- Overflow: A=0x7FE0000000000000, B=0x3FE0000000000000 -> overflow=1, result=0x7FF0000000000000. Underflow: A=0x0010000000000000, B=0x4000000000000000 -> underflow=1, result=0x0.
- Divide by zero: A=0x3FF0000000000000, B=0x0 -> div_by_zero=1, result=0x7FF0000000000000. Zero dividend: A=0x8000000000000000, B=0x4000000000000000 -> result=0x8000000000000000, no flags.
- Handshake: start held high for 70 cycles with operands changing every cycle -> only the first operands used; second accept occurs in the IDLE cycle after done; exactly one done per accept.
- Reset asserted at CALC cycle 20 (asynchronously, between edges) -> all outputs 0 immediately, no done pulse; next start completes normally with correct result.

Source files
------------

// File: rtl/fpu_dp_divider.sv
// ----------------------------------------------------------------------------
// fpu_dp_divider
//   Iterative binary64 divider (result = A / B). Restoring radix-2 division,
//   one quotient bit per clock, with a start/done handshake. Arithmetic and
//   flag behaviour follow the FPU multiplier: mantissa truncation, implicit
//   bit derived from a non-zero exponent, and no NaN/Inf decoding.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, only sampled in IDLE
//   A, B         dividend / divisor, captured on the accepting edge
//   busy         high from the accepting edge until done is asserted
//   done         one-cycle pulse when result and flags become valid
//   result       quotient, held until the next NORM
//   overflow     exponent too large
//   underflow    exponent too small (non-zero dividend)
//   div_by_zero  divisor exponent and mantissa both zero
// ----------------------------------------------------------------------------
module fpu_dp_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_NORM,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [63:0]  r_a;
    logic [63:0]  r_b;
    logic [54:0]  r_rem;
    logic [54:0]  r_quo;
    logic [5:0]   r_cnt;

    logic [52:0]  w_ma_in;
    logic [52:0]  w_mb;
    logic [54:0]  w_rem_sh;
    logic [55:0]  w_diff;
    logic         w_qbit;
    logic         w_sign;
    logic         w_a_zero;
    logic         w_b_zero;
    logic [51:0]  w_mant;
    logic [12:0]  w_exp;

    // Mantissas with the implicit bit set for any non-zero exponent.
    assign w_ma_in  = {|A[62:52], A[51:0]};
    assign w_mb     = {|r_b[62:52], r_b[51:0]};

    // The remainder starts at Ma and is compared against 2*Mb after each
    // shift, which is floor(Ma*2^54/Mb) scaled so that every one of the 55
    // cycles is a uniform shift/trial-subtract step.
    assign w_rem_sh = {r_rem[53:0], 1'b0};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, w_mb, 1'b0};
    assign w_qbit   = ~w_diff[55];

    assign w_sign   = r_a[63] ^ r_b[63];
    assign w_a_zero = ~|r_a[62:0];
    assign w_b_zero = ~|r_b[62:0];
    assign w_mant   = r_quo[54] ? r_quo[53:2] : r_quo[52:1];
    assign w_exp    = 13'({2'b00, r_a[62:52]}) - 13'({2'b00, r_b[62:52]})
                    + (r_quo[54] ? 13'd1023 : 13'd1022);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_rem   <= {2'b00, w_ma_in};
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_qbit ? w_diff[54:0] : w_rem_sh;
                    r_quo   <= {r_quo[53:0], w_qbit};
                    r_cnt   <= r_cnt + 6'd1;
                    if (r_cnt == 6'd54) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (w_b_zero) begin
                        div_by_zero <= 1'b1;
                        result      <= {w_sign, 11'h7FF, 52'd0};
                    end else if (w_a_zero) begin
                        result      <= {w_sign, 63'd0};
                    end else if ($signed(w_exp) >= $signed(13'd2047)) begin
                        overflow    <= 1'b1;
                        result      <= {w_sign, 11'h7FF, 52'd0};
                    end else if ($signed(w_exp) <= $signed(13'd0)) begin
                        underflow   <= 1'b1;
                        result      <= {w_sign, 63'd0};
                    end else begin
                        result      <= {w_sign, w_exp[10:0], w_mant};
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_dp_divider.sv
module tb_fpu_dp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    typedef struct {
        logic [63:0] r;
        logic        ov;
        logic        un;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   accepts  = 0;
    int   dones    = 0;

    fpu_dp_divider #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .underflow  (underflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: pops the next expected response whenever done pulses.
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=no_done cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",      result,      e.r);
                chk("overflow",    64'(overflow),    64'(e.ov));
                chk("underflow",   64'(underflow),   64'(e.un));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("latency",     64'(cyc),         64'(e.due));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge: the accepting edge is the next posedge.
    task automatic push_exp(input logic [63:0] r, input logic ov, input logic un, input logic dz);
        exp_t e;
        e.r   = r;
        e.ov  = ov;
        e.un  = un;
        e.dz  = dz;
        e.due = cyc + 1 + 57;
        sb.push_back(e);
        accepts++;
    endtask

    task automatic drain(input logic [63:0] r);
        int i;
        for (i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=pending%0d expected=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("result_held",    result,    r);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                          input logic ov, input logic un, input logic dz);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        push_exp(r, ov, un, dz);
        @(negedge clk);
        start = 1'b0;
        A = '1;
        B = '1;
        chk("busy_after_accept", 64'(busy), 64'd1);
        drain(r);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        chk("reset_result", result, 64'd0);
        chk("reset_flags",  64'({busy, done, overflow, underflow, div_by_zero}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 0, 0, 0);
        run_op(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 0, 0, 0);
        run_op(64'hC000000000000000, 64'h3FE0000000000000, 64'hC010000000000000, 0, 0, 0);
        run_op(64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 1, 0, 0);
        run_op(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 0, 1, 0);
        run_op(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 0, 0, 1);
        run_op(64'h8000000000000000, 64'h4000000000000000, 64'h8000000000000000, 0, 0, 0);
        run_op(64'h3FFFFFFFFFFFFFFF, 64'h3FF0000000000000, 64'h3FFFFFFFFFFFFFFF, 0, 0, 0);
        run_op(64'h0008000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 0, 1, 0);
        run_op(64'hBFF0000000000000, 64'hBFF0000000000000, 64'h3FF0000000000000, 0, 0, 0);

        // start held high with operands changing every cycle; accepts land on
        // iterations 0 and 58, all other cycles carry decoy operands.
        @(negedge clk);
        for (int i = 0; i < 70; i++) begin
            start = 1'b1;
            if (i == 0) begin
                A = 64'h4018000000000000;
                B = 64'h4000000000000000;
                push_exp(64'h4008000000000000, 0, 0, 0);
            end else if (i == 58) begin
                A = 64'hC000000000000000;
                B = 64'h3FE0000000000000;
                push_exp(64'hC010000000000000, 0, 0, 0);
            end else begin
                A = 64'h7FE0000000000000 + 64'(i);
                B = 64'h0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain(64'hC010000000000000);

        // Reset mid-CALC: outputs drop at once and the aborted op never completes.
        @(negedge clk);
        A = 64'h4018000000000000;
        B = 64'h4000000000000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_result", result, 64'd0);
        chk("abort_flags",  64'({busy, done, overflow, underflow, div_by_zero}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("abort_no_done_busy", 64'(busy), 64'd0);
        run_op(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 0, 0, 0);

        chk("done_count", 64'(dones), 64'(accepts));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
